acc_result_writer: RTL and testbench
====================================

# acc_result_writer

Write-back engine for the accelerator's output tiles. It captures one POY×POX result tile from the PE array and writes it to DRAM over the team's reduced AXI write channel, one burst per output row. This is the mirror of the accelerator's AXI read ports: it is the write initiator on a bus whose far end is an `sdram_sim`-style responder. It sits between the accelerator's `result`/`result_valid` array and a third `axi_bus_if` instance.

## Interface
Parameters:
- `DW`, 32: data width; one result word per beat.
- `AW`, 32: address width; addresses are word addresses, +1 per beat.
- `POX`, 15: tile width; also the number of beats per burst.
- `POY`, 3: tile height; also the number of bursts per tile.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `tile_valid` in 1: a tile is presented on `result`.
- `tile_ready` out 1: the block can capture a tile.
- `result[POY][POX]` in DW: tile data.
- `tile_addr` in AW: word address of element [0][0].
- `row_pitch` in AW: word offset between consecutive rows.
- `tile_done` out 1: one-cycle pulse when the tile is fully written and acknowledged.
- `wr_err` out 1: sticky; set on any non-OKAY `bresp`.
- `err_clr` in 1: clears `wr_err`.
- `awaddr` out AW: burst start address.
- `awburst` out 2: burst type; constant INCR (2'b01).
- `awvalid` out 1 and `awready` in 1: address handshake.
- `wdata` out DW: write data.
- `wlast` out 1: marks the final beat of a burst.
- `wvalid` out 1 and `wready` in 1: data handshake.
- `bresp` in 2: write response code.
- `bvalid` in 1 and `bready` out 1: response handshake.

## Operation
- States: IDLE → AW → W → B → (AW | DONE) → IDLE.
- IDLE:
  - `tile_ready`=1.
  - On `tile_valid&&tile_ready`, latch all POY×POX words into the tile buffer and latch `row_pitch`.
  - Set `row_addr`=`tile_addr`, `y`=0, `x`=0; go to AW.
- AW:
  - `awvalid`=1, `awaddr`=`row_addr`.
  - On `awready`, go to W.
- W:
  - `wvalid`=1, `wdata`=buf[y][x], `wlast`=(x==POX-1).
  - On `wready`, increment x.
  - On the `wlast` beat with `wready`, set x=0 and go to B.
- B:
  - `bready`=1.
  - On `bvalid`: if `bresp`≠2'b00, set `wr_err`.
  - Then, if y==POY-1, go to DONE; otherwise y++, `row_addr` += latched pitch (mod 2^AW), go to AW.
- DONE: `tile_done`=1 for exactly one cycle, then IDLE.
- The address is accumulated with an adder; no multiplier.
- Each burst has exactly POX beats. The bus has no length field; `wlast` alone delimits a burst.
- An error does not abort the tile. All POY bursts are always issued.
- `err_clr` and a new error in the same cycle: the set wins.
- `tile_valid` and `result` are ignored outside IDLE. The upstream source must hold data until it sees `tile_ready`.

## Timing
- Reset values: all outputs 0, except `awburst`=2'b01. State is IDLE, x=y=0, `wr_err`=0. `tile_ready` becomes 1 on the first cycle after reset release.
- Reset mid-operation:
  - All channel valids drop immediately (asynchronously).
  - The partially sent burst is abandoned; no further beats are sent.
  - The tile is lost, and no `tile_done` is issued.
- Capture to `awvalid`: 1 cycle (the capture edge moves the state to AW).
- Valids are registered outputs. Once asserted, `awvalid`/`wvalid` stay asserted and their address/data stay stable until the handshake completes.
- W begins only after the AW handshake; AW and W never overlap. The first `wvalid` is the cycle after the `awready` handshake.
- With zero backpressure: per row, 1 AW cycle + POX W cycles + ≥1 B cycle. The tile takes POY·(POX+2)+1 cycles from capture to `tile_done`, i.e. 52 for 15×3.
- `tile_ready` is 0 from the cycle after capture through the DONE cycle. It returns to 1 the cycle after `tile_done`.

## Structure
- Shared `acc_pkg`:
  - state enum `wr_state_t` {IDLE, AW, W, B, DONE};
  - `AXI_BURST_INCR`=2'b01;
  - response codes `AXI_RESP_OKAY`/`SLVERR`/`DECERR`.
- Single module, no sub-modules. The tile buffer is a flop array indexed by the x/y counters.

## Test plan
- **Basic tile (POX=15, POY=3):** `tile_addr`=0x100, `row_pitch`=64, result[y][x]=y*16+x, always-ready responder.
  - `awaddr` sequence is 0x100, 0x140, 0x180.
  - 45 beats in row order; `wlast` on beats 15, 30 and 45.
  - One `tile_done`, 52 cycles after capture.
- **AW backpressure:** `awready` held low for 5 cycles on row 1.
  - `awaddr`=0x140 is held stable throughout.
  - No `wvalid` appears before the handshake.
  - Total time is 57 cycles.
- **W backpressure:** `wready` toggles 1010…
  - `wdata`/`wlast` are held during each stall.
  - No beat is dropped or duplicated; the scoreboard matches all 45 words.
- **Error response:** `bresp`=SLVERR on row 1 only.
  - `wr_err` rises in that B cycle.
  - Row 2 is still written and `tile_done` still pulses.
  - `err_clr` then clears `wr_err`.
- **Reset mid-burst:** `rst_n` pulled low at beat 7 of row 0.
  - All valids are 0 during reset.
  - After release, `tile_ready`=1 with no `tile_done`.
  - A fresh tile then writes correctly.
- **Back-to-back tiles with address wrap:** `tile_valid` held high, second tile at `tile_addr`=0xFFFF_FFF0 with `row_pitch`=0x10.
  - Second tile is captured the cycle after the first `tile_done`.
  - `awaddr` sequence is 0xFFFF_FFF0, 0x0, 0x10.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared accelerator types and AXI write-channel constants.
// Latency: none (types and constants only).
// Backpressure: none.
package acc_pkg;

  // Write-back engine states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AW   = 3'd1,
    W    = 3'd2,
    B    = 3'd3,
    DONE = 3'd4
  } wr_state_t;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/acc_result_writer.sv
// Captures one POY x POX result tile and writes it out as POY INCR bursts of POX beats each.
// Latency: awvalid 1 cycle after capture; tile_done POY*(POX+2)+1 cycles after capture with no stalls.
// Backpressure: tile_ready low while a tile is in flight; each channel holds valid/payload until its handshake.
module acc_result_writer
  import acc_pkg::*;
#(
  parameter int DW  = 32,
  parameter int AW  = 32,
  parameter int POX = 15,
  parameter int POY = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tile_valid,
  output logic          tile_ready,
  input  logic [DW-1:0] result [POY][POX],
  input  logic [AW-1:0] tile_addr,
  input  logic [AW-1:0] row_pitch,
  output logic          tile_done,
  output logic          wr_err,
  input  logic          err_clr,
  output logic [AW-1:0] awaddr,
  output logic [1:0]    awburst,
  output logic          awvalid,
  input  logic          awready,
  output logic [DW-1:0] wdata,
  output logic          wlast,
  output logic          wvalid,
  input  logic          wready,
  input  logic [1:0]    bresp,
  input  logic          bvalid,
  output logic          bready
);

  localparam int XW = (POX > 1) ? $clog2(POX) : 1;
  localparam int YW = (POY > 1) ? $clog2(POY) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(POX - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(POY - 1);

  // The address-width parameter shadows the AW state name, so states are
  // always written package-qualified below.
  wr_state_t     state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW-1:0] row_addr_q, row_addr_d;
  logic [AW-1:0] pitch_q, pitch_d;
  logic          wr_err_q, wr_err_d;
  logic          capture;

  logic [DW-1:0] buf_q [POY][POX];
  logic [DW-1:0] buf_d [POY][POX];

  logic          awvalid_q, awvalid_d;
  logic [AW-1:0] awaddr_q, awaddr_d;
  logic          wvalid_q, wvalid_d;
  logic          wlast_q, wlast_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          bready_q, bready_d;
  logic          tile_ready_q, tile_ready_d;
  logic          tile_done_q, tile_done_d;

  // Next-state, counters, row address accumulation and sticky error.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    row_addr_d = row_addr_q;
    pitch_d    = pitch_q;
    wr_err_d   = wr_err_q;
    capture    = 1'b0;
    case (state_q)
      acc_pkg::IDLE: begin
        if (tile_valid && tile_ready_q) begin
          capture    = 1'b1;
          pitch_d    = row_pitch;
          row_addr_d = tile_addr;
          x_d        = '0;
          y_d        = '0;
          state_d    = acc_pkg::AW;
        end
      end
      acc_pkg::AW: begin
        if (awready) state_d = acc_pkg::W;
      end
      acc_pkg::W: begin
        if (wready) begin
          if (x_q == X_LAST) begin
            x_d     = '0;
            state_d = acc_pkg::B;
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      acc_pkg::B: begin
        if (bvalid) begin
          if (y_q == Y_LAST) begin
            state_d = acc_pkg::DONE;
          end else begin
            y_d        = y_q + YW'(1);
            row_addr_d = row_addr_q + pitch_q;
            state_d    = acc_pkg::AW;
          end
        end
      end
      acc_pkg::DONE: state_d = acc_pkg::IDLE;
      default:       state_d = acc_pkg::IDLE;
    endcase
    // A new error response beats a simultaneous clear.
    if (err_clr) wr_err_d = 1'b0;
    if ((state_q == acc_pkg::B) && bvalid && (bresp != AXI_RESP_OKAY)) wr_err_d = 1'b1;
  end

  // Tile buffer loads the whole array on capture and holds it otherwise.
  always_comb begin
    buf_d = capture ? result : buf_q;
  end

  // Registered channel outputs are decoded from the next state so they line up with it.
  always_comb begin
    awvalid_d    = (state_d == acc_pkg::AW);
    awaddr_d     = row_addr_d;
    wvalid_d     = (state_d == acc_pkg::W);
    wlast_d      = wvalid_d && (x_d == X_LAST);
    wdata_d      = wvalid_d ? buf_q[y_d][x_d] : '0;
    bready_d     = (state_d == acc_pkg::B);
    tile_ready_d = (state_d == acc_pkg::IDLE);
    tile_done_d  = (state_d == acc_pkg::DONE);
  end

  // Control and output registers; reset drops every valid at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= acc_pkg::IDLE;
      x_q          <= '0;
      y_q          <= '0;
      row_addr_q   <= '0;
      pitch_q      <= '0;
      wr_err_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      awaddr_q     <= '0;
      wvalid_q     <= 1'b0;
      wlast_q      <= 1'b0;
      wdata_q      <= '0;
      bready_q     <= 1'b0;
      tile_ready_q <= 1'b0;
      tile_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      row_addr_q   <= row_addr_d;
      pitch_q      <= pitch_d;
      wr_err_q     <= wr_err_d;
      awvalid_q    <= awvalid_d;
      awaddr_q     <= awaddr_d;
      wvalid_q     <= wvalid_d;
      wlast_q      <= wlast_d;
      wdata_q      <= wdata_d;
      bready_q     <= bready_d;
      tile_ready_q <= tile_ready_d;
      tile_done_q  <= tile_done_d;
    end
  end

  // Tile buffer is pure datapath and needs no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign tile_ready = tile_ready_q;
  assign tile_done  = tile_done_q;
  assign wr_err     = wr_err_q;
  assign awaddr     = awaddr_q;
  assign awburst    = AXI_BURST_INCR;
  assign awvalid    = awvalid_q;
  assign wdata      = wdata_q;
  assign wlast      = wlast_q;
  assign wvalid     = wvalid_q;
  assign bready     = bready_q;

endmodule

// File: tb/tb_acc_result_writer.sv
// Directed bench for acc_result_writer with a responder and scoreboard.
// Latency: checks capture-to-done timing against hand-computed cycle counts.
// Backpressure: drives AW stalls, toggling wready and error responses.
module tb_acc_result_writer;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int POX = 15;
  localparam int POY = 3;

  logic          clk, rst_n, tile_valid, tile_ready, tile_done, wr_err, err_clr;
  logic [DW-1:0] result [POY][POX];
  logic [AW-1:0] tile_addr, row_pitch, awaddr;
  logic [1:0]    awburst, bresp;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [DW-1:0] wdata;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  int aw_n, beat_n, b_n, cap_n, done_n, viol, pending;
  int stall_row, err_row, aw_stall_cnt;
  logic [AW-1:0] aw_log   [16];
  logic [DW-1:0] beat_dat [128];
  logic          beat_last[128];
  int cap_cyc [4];
  int done_cyc[4];
  bit wtog_mode, wtog, aw_open, prev_aw_stall, prev_w_stall, err_probe;
  logic err_before, err_after;
  logic [AW-1:0] prev_awaddr;
  logic [DW-1:0] prev_wdata;
  logic          prev_wlast;

  acc_result_writer #(.DW(DW), .AW(AW), .POX(POX), .POY(POY)) dut (
    .clk(clk), .rst_n(rst_n),
    .tile_valid(tile_valid), .tile_ready(tile_ready),
    .result(result), .tile_addr(tile_addr), .row_pitch(row_pitch),
    .tile_done(tile_done), .wr_err(wr_err), .err_clr(err_clr),
    .awaddr(awaddr), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Responder and monitor: readys are set on the falling edge, then the
  // handshakes that the next rising edge will complete are logged.
  initial begin
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; pending = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pending = 0; bvalid = 1'b0; aw_open = 1'b0;
        prev_aw_stall = 1'b0; prev_w_stall = 1'b0; err_probe = 1'b0;
      end else begin
        cyc++;
        if (err_probe) begin err_after = wr_err; err_probe = 1'b0; end
        if (awvalid && aw_n == stall_row && aw_stall_cnt < 5) begin
          awready = 1'b0; aw_stall_cnt++;
        end else begin
          awready = 1'b1;
        end
        if (wtog_mode) begin wready = wtog; wtog = !wtog; end
        else wready = 1'b1;
        bvalid = (pending > 0);
        bresp  = (bvalid && b_n == err_row) ? 2'b10 : 2'b00;
        if (prev_aw_stall && (!awvalid || awaddr !== prev_awaddr)) viol++;
        if (prev_w_stall && (!wvalid || wdata !== prev_wdata || wlast !== prev_wlast)) viol++;
        if (awvalid && wvalid) viol++;
        if (wvalid && !aw_open) viol++;
        if (awvalid && awready) begin
          if (aw_n < 16) aw_log[aw_n] = awaddr;
          aw_n++; aw_open = 1'b1;
        end
        if (wvalid && wready) begin
          if (beat_n < 128) begin beat_dat[beat_n] = wdata; beat_last[beat_n] = wlast; end
          beat_n++;
          if (wlast) begin pending++; aw_open = 1'b0; end
        end
        if (bvalid && bready) begin
          if (b_n == err_row) begin err_before = wr_err; err_probe = 1'b1; end
          pending--; b_n++;
        end
        if (tile_valid && tile_ready) begin
          if (cap_n < 4) cap_cyc[cap_n] = cyc;
          cap_n++;
        end
        if (tile_done) begin
          if (done_n < 4) done_cyc[done_n] = cyc;
          done_n++;
        end
        prev_aw_stall = awvalid && !awready; prev_awaddr = awaddr;
        prev_w_stall  = wvalid && !wready;   prev_wdata  = wdata; prev_wlast = wlast;
      end
    end
  end

  task automatic clear_logs();
    aw_n = 0; beat_n = 0; b_n = 0; cap_n = 0; done_n = 0; viol = 0;
    stall_row = -1; err_row = -1; aw_stall_cnt = 0;
    wtog_mode = 1'b0; wtog = 1'b1; err_before = 1'bx; err_after = 1'bx;
  endtask

  task automatic load_tile(input int base, input logic [AW-1:0] addr, input logic [AW-1:0] pitch);
    for (int y = 0; y < POY; y++)
      for (int x = 0; x < POX; x++)
        result[y][x] = DW'(base + y * 16 + x);
    tile_addr = addr;
    row_pitch = pitch;
  endtask

  task automatic wait_capture(input int want);
    int t = 0;
    while (cap_n < want && t < 200) begin @(posedge clk); #1; t++; end
    chk("capture_seen", 64'(cap_n >= want), 64'(1));
  endtask

  task automatic wait_done(input int want);
    int t = 0;
    while (done_n < want && t < 400) begin @(posedge clk); #1; t++; end
    chk("done_seen", 64'(done_n >= want), 64'(1));
  endtask

  // Compares three burst addresses and 45 beats (data y*16+x+base, wlast every 15th).
  task automatic check_tile(input string nm, input int b0, input int a0, input int base,
                            input logic [AW-1:0] ea0, input logic [AW-1:0] ea1,
                            input logic [AW-1:0] ea2);
    int derr = 0;
    int lerr = 0;
    logic [DW-1:0] e;
    chk({nm, "_aw0"}, 64'(aw_log[a0]),     64'(ea0));
    chk({nm, "_aw1"}, 64'(aw_log[a0 + 1]), 64'(ea1));
    chk({nm, "_aw2"}, 64'(aw_log[a0 + 2]), 64'(ea2));
    for (int i = 0; i < POX * POY; i++) begin
      e = DW'(base + (i / POX) * 16 + (i % POX));
      if (beat_dat[b0 + i] !== e) derr++;
      if (beat_last[b0 + i] !== ((i % POX) == POX - 1)) lerr++;
    end
    chk({nm, "_data_errs"}, 64'(derr), 64'(0));
    chk({nm, "_wlast_errs"}, 64'(lerr), 64'(0));
  endtask

  task automatic run_tile(input int base, input logic [AW-1:0] addr, input logic [AW-1:0] pitch);
    load_tile(base, addr, pitch);
    tile_valid = 1'b1;
    wait_capture(1);
    tile_valid = 1'b0;
    wait_done(1);
  endtask

  initial begin
    int t;
    rst_n = 1'b0; tile_valid = 1'b0; err_clr = 1'b0;
    load_tile(0, '0, '0);
    clear_logs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valids",     64'({awvalid, wvalid, wlast, bready}), 64'(0));
    chk("rst_tile_flags", 64'({tile_ready, tile_done, wr_err}), 64'(0));
    chk("rst_awburst",    64'(awburst), 64'(2'b01));
    chk("rst_awaddr",     64'(awaddr), 64'(0));
    chk("rst_wdata",      64'(wdata), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 64'(tile_ready), 64'(1));

    // Basic tile, always-ready responder.
    clear_logs();
    run_tile(0, 32'h100, 32'd64);
    chk("basic_ready_after_done", 64'({tile_ready, tile_done}), 64'(2'b10));
    repeat (3) @(posedge clk);
    #1;
    check_tile("basic", 0, 0, 0, 32'h100, 32'h140, 32'h180);
    chk("basic_beats",   64'(beat_n), 64'(45));
    chk("basic_latency", 64'(done_cyc[0] - cap_cyc[0]), 64'(52));
    chk("basic_done_n",  64'(done_n), 64'(1));
    chk("basic_viol",    64'(viol), 64'(0));

    // AW backpressure on row 1.
    clear_logs();
    stall_row = 1;
    run_tile(32'h1000, 32'h100, 32'd64);
    check_tile("awbp", 0, 0, 32'h1000, 32'h100, 32'h140, 32'h180);
    chk("awbp_latency", 64'(done_cyc[0] - cap_cyc[0]), 64'(57));
    chk("awbp_stalls",  64'(aw_stall_cnt), 64'(5));
    chk("awbp_viol",    64'(viol), 64'(0));

    // W backpressure, wready toggling 1010...
    clear_logs();
    wtog_mode = 1'b1;
    run_tile(32'h700, 32'h2000, 32'h100);
    check_tile("wbp", 0, 0, 32'h700, 32'h2000, 32'h2100, 32'h2200);
    chk("wbp_beats", 64'(beat_n), 64'(45));
    chk("wbp_viol",  64'(viol), 64'(0));

    // SLVERR on row 1 only.
    clear_logs();
    err_row = 1;
    run_tile(32'h40, 32'h300, 32'h10);
    check_tile("err", 0, 0, 32'h40, 32'h300, 32'h310, 32'h320);
    chk("err_before",   64'(err_before), 64'(0));
    chk("err_after",    64'(err_after), 64'(1));
    chk("err_sticky",   64'(wr_err), 64'(1));
    chk("err_b_count",  64'(b_n), 64'(3));
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("err_cleared",  64'(wr_err), 64'(0));

    // Reset in the middle of row 0.
    clear_logs();
    load_tile(32'h500, 32'h400, 32'h40);
    tile_valid = 1'b1;
    wait_capture(1);
    tile_valid = 1'b0;
    t = 0;
    while (beat_n < 7 && t < 100) begin @(posedge clk); #1; t++; end
    chk("rst_mid_reached_beat7", 64'(beat_n), 64'(7));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valids_async", 64'({awvalid, wvalid, bready, tile_done}), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_valids_held", 64'({awvalid, wvalid, bready}), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ready", 64'(tile_ready), 64'(1));
    repeat (5) @(posedge clk);
    #1;
    chk("rst_mid_no_more_beats", 64'(beat_n), 64'(7));
    chk("rst_mid_no_done",       64'(done_n), 64'(0));
    chk("rst_mid_aw_count",      64'(aw_n), 64'(1));
    clear_logs();
    run_tile(32'h600, 32'h800, 32'h100);
    check_tile("post_rst", 0, 0, 32'h600, 32'h800, 32'h900, 32'hA00);
    chk("post_rst_latency", 64'(done_cyc[0] - cap_cyc[0]), 64'(52));

    // Back-to-back tiles, second one wrapping the address space.
    clear_logs();
    load_tile(32'h2000, 32'h200, 32'h20);
    tile_valid = 1'b1;
    wait_capture(1);
    load_tile(32'h3000, 32'hFFFF_FFF0, 32'h10);
    wait_capture(2);
    tile_valid = 1'b0;
    wait_done(2);
    repeat (2) @(posedge clk);
    #1;
    check_tile("b2b_t0", 0, 0, 32'h2000, 32'h200, 32'h220, 32'h240);
    check_tile("b2b_t1", 45, 3, 32'h3000, 32'hFFFF_FFF0, 32'h0, 32'h10);
    chk("b2b_capture_gap", 64'(cap_cyc[1] - done_cyc[0]), 64'(1));
    chk("b2b_beats",       64'(beat_n), 64'(90));
    chk("b2b_viol",        64'(viol), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
